// File: rtl/btn_spi_cmd_sched.sv
// btn_spi_cmd_sched
// Turns one-cycle button events from three debounced channels into command
// bytes for a single shared SPI-master transmit port. Pending events are
// served round-robin, with one transaction outstanding at a time.
// Optional build macro BTN_SCHED_DROP_CNT_EN enables a saturating counter of
// merged (coalesced) button events on drop_cnt; otherwise drop_cnt is 0.
module btn_spi_cmd_sched #(
    parameter int unsigned TIMEOUT = 1000,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       btn_pulse,
    input  logic             spi_ready,
    input  logic             spi_done,
    output logic             spi_start,
    output logic [7:0]       spi_tx_data,
    output logic             run_state,
    output logic             mode_state,
    output logic             busy,
    output logic [1:0]       grant_id,
    output logic             timeout_err,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int unsigned   TW     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_START,
        ST_WAIT
    } state_t;

    state_t        state, state_n;
    logic [2:0]    pending, pending_n, clr;
    logic [1:0]    sel, search_base, cand;
    logic          sel_vld;
    logic          tmo_hit;
    logic [TW-1:0] tmo_cnt;

    // Round-robin pick: first pending bit starting just after the last grant.
    always_comb begin
        search_base = (grant_id == 2'd2) ? 2'd0 : grant_id + 2'd1;
        cand        = search_base;
        sel         = 2'd0;
        sel_vld     = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            if (!sel_vld && pending[cand]) begin
                sel     = cand;
                sel_vld = 1'b1;
            end
            cand = (cand == 2'd2) ? 2'd0 : cand + 2'd1;
        end
    end

    // Next-state logic; incoming pulses count in IDLE so GRANT follows the pulse directly.
    always_comb begin
        state_n = state;
        clr     = 3'b000;
        tmo_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (((pending | btn_pulse) != 3'b000) && spi_ready)
                    state_n = ST_GRANT;
            end
            ST_GRANT: begin
                if (sel_vld) begin
                    clr     = 3'b001 << sel;
                    state_n = ST_START;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_START: state_n = ST_WAIT;
            ST_WAIT: begin
                if (spi_done) begin
                    state_n = ST_IDLE;
                end else if (tmo_cnt == T_LAST) begin
                    state_n = ST_IDLE;
                    tmo_hit = 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // A new pulse on the index being cleared survives (set wins).
        pending_n = (pending & ~clr) | btn_pulse;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    // Pending flags, grant bookkeeping, command byte and timeout tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending     <= 3'b000;
            grant_id    <= 2'd2;
            run_state   <= 1'b0;
            mode_state  <= 1'b0;
            spi_tx_data <= 8'h00;
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            pending     <= pending_n;
            timeout_err <= timeout_err | tmo_hit;
            // Counter reads 0 during START and then counts cycles since spi_start.
            if (state == ST_GRANT)
                tmo_cnt <= '0;
            else if (state != ST_IDLE)
                tmo_cnt <= tmo_cnt + 1'b1;
            if (state == ST_GRANT && sel_vld) begin
                grant_id <= sel;
                case (sel)
                    2'd0: begin
                        run_state   <= ~run_state;
                        spi_tx_data <= {7'b1000000, ~run_state};
                    end
                    2'd1: spi_tx_data <= 8'h90;
                    default: begin
                        mode_state  <= ~mode_state;
                        spi_tx_data <= {7'b1010000, ~mode_state};
                    end
                endcase
            end
        end
    end

    assign spi_start = (state == ST_START);
    assign busy      = (state != ST_IDLE);

`ifdef BTN_SCHED_DROP_CNT_EN
    logic [2:0]       merged;
    logic [1:0]       merge_n;
    logic [CNT_W+1:0] drop_sum;
    logic [CNT_W-1:0] drop_q;

    // Count pulses landing on an already-pending index that is not being served.
    always_comb begin
        merged   = btn_pulse & pending & ~clr;
        merge_n  = {1'b0, merged[0]} + {1'b0, merged[1]} + {1'b0, merged[2]};
        drop_sum = {2'b00, drop_q} + {{CNT_W{1'b0}}, merge_n};
    end

    // Saturating merged-event counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            drop_q <= '0;
        else if (drop_sum[CNT_W+1:CNT_W] != 2'b00)
            drop_q <= '1;
        else
            drop_q <= drop_sum[CNT_W-1:0];
    end

    assign drop_cnt = drop_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_btn_spi_cmd_sched.sv
// Self-checking bench for btn_spi_cmd_sched: randomized and directed
// stimulus, a transaction-level reference model, and a scoreboard queue of
// expected command bytes popped by an independent monitor.
module tb_btn_spi_cmd_sched;

    localparam int TIMEOUT  = 16;
    localparam int CNT_W    = 4;
    localparam int DROP_MAX = (1 << CNT_W) - 1;
    localparam int P_IDLE = 0, P_GRANT = 1, P_START = 2, P_WAIT = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [2:0]       btn_pulse = 3'b000;
    logic             spi_ready = 1'b1;
    logic             spi_done  = 1'b0;
    logic             spi_start;
    logic [7:0]       spi_tx_data;
    logic             run_state, mode_state, busy, timeout_err;
    logic [1:0]       grant_id;
    logic [CNT_W-1:0] drop_cnt;

    btn_spi_cmd_sched #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .btn_pulse(btn_pulse), .spi_ready(spi_ready),
        .spi_done(spi_done), .spi_start(spi_start), .spi_tx_data(spi_tx_data),
        .run_state(run_state), .mode_state(mode_state), .busy(busy),
        .grant_id(grant_id), .timeout_err(timeout_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit         mp[3];
    int         m_phase = P_IDLE;
    int         m_last = 2;
    bit         m_run = 0, m_mode = 0, m_terr = 0;
    int         m_elapsed = 0;
    int         m_drop = 0;
    logic [7:0] exp_q[$];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) mp[i] = 0;
        m_phase = P_IDLE; m_last = 2; m_run = 0; m_mode = 0;
        m_terr = 0; m_elapsed = 0; m_drop = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [2:0] p, input logic r, input logic d);
        int sel = -1;
        case (m_phase)
            P_IDLE: if ((mp[0] || mp[1] || mp[2] || p != 3'b000) && r) m_phase = P_GRANT;
            P_GRANT: begin
                for (int k = 0; k < 3; k++) begin
                    int i = (m_last + 1 + k) % 3;
                    if (sel < 0 && mp[i]) sel = i;
                end
                if (sel < 0) m_phase = P_IDLE;
                else begin
                    m_last = sel;
                    mp[sel] = 0;
                    if (sel == 0) begin m_run = !m_run; exp_q.push_back(m_run ? 8'h81 : 8'h80); end
                    else if (sel == 1) exp_q.push_back(8'h90);
                    else begin m_mode = !m_mode; exp_q.push_back(m_mode ? 8'hA1 : 8'hA0); end
                    m_phase = P_START;
                end
            end
            P_START: begin m_phase = P_WAIT; m_elapsed = 1; end
            default: begin
                if (d) m_phase = P_IDLE;
                else if (m_elapsed == TIMEOUT - 1) begin m_phase = P_IDLE; m_terr = 1; end
                else m_elapsed++;
            end
        endcase
        for (int i = 0; i < 3; i++) begin
            if (p[i]) begin
                if (mp[i] && m_drop < DROP_MAX) m_drop++;
                mp[i] = 1;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else     model_step(btn_pulse, spi_ready, spi_done);
        end
    end

    function automatic int exp_drop();
`ifdef BTN_SCHED_DROP_CNT_EN
        return m_drop;
`else
        return 0;
`endif
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        chk("spi_start", 32'(spi_start), 32'(m_phase == P_START));
        chk("busy", 32'(busy), 32'(m_phase != P_IDLE));
        chk("grant_id", 32'(grant_id), 32'(m_last));
        chk("run_state", 32'(run_state), 32'(m_run));
        chk("mode_state", 32'(mode_state), 32'(m_mode));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop()));
        if (spi_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spi_tx_data: got %0h expected none queued", spi_tx_data);
            end else begin
                e = exp_q.pop_front();
                chk("spi_tx_data", 32'(spi_tx_data), 32'(e));
            end
        end
    end

    // ---------------- SPI master responder ----------------
    bit resp_en = 1, stray_en = 0;
    int resp_lo = 3, resp_hi = 3;
    int cd = 0;

    always @(negedge clk) begin
        if (rst) begin
            cd = 0;
            spi_done = 1'b0;
        end else begin
            spi_done = (cd == 1) || (stray_en && $urandom_range(0, 15) == 0);
            if (cd > 0) cd--;
            if (spi_start === 1'b1 && resp_en) cd = $urandom_range(resp_lo, resp_hi);
        end
    end

    // ---------------- stimulus ----------------
    task automatic pulse(input logic [2:0] m);
        btn_pulse = m;
        @(negedge clk);
        btn_pulse = 3'b000;
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while (!(m_phase == P_IDLE && !mp[0] && !mp[1] && !mp[2] && busy === 1'b0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_quiet: still busy after %0d cycles, required idle", n);
        end
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (spi_start !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_start: no spi_start in %0d cycles, required one", n);
        end
    endtask

    initial begin
        int d0, n, starts;
        repeat (3) @(negedge clk);
        chk("rst_spi_start", 32'(spi_start), 0);
        chk("rst_tx_data", 32'(spi_tx_data), 0);
        chk("rst_grant_id", 32'(grant_id), 2);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // first command and its exact latency: spi_start two cycles after the pulse
        btn_pulse = 3'b001;
        @(negedge clk);
        btn_pulse = 3'b000;
        chk("lat_grant_cycle", 32'(spi_start), 0);
        @(negedge clk);
        chk("lat_start_cycle", 32'(spi_start), 1);
        chk("first_byte", 32'(spi_tx_data), 32'h81);
        chk("first_run", 32'(run_state), 1);
        wait_quiet(100);
        pulse(3'b001); wait_quiet(100);
        pulse(3'b001); wait_quiet(100);
        pulse(3'b111); wait_quiet(200);

        // three btn1 pulses while a transaction is in WAIT
        resp_lo = 12; resp_hi = 12;
        pulse(3'b001);
        wait_start(20);
        @(negedge clk); @(negedge clk);
        d0 = int'(drop_cnt);
        pulse(3'b010); pulse(3'b010); pulse(3'b010);
        wait_quiet(200);
`ifdef BTN_SCHED_DROP_CNT_EN
        chk("merge_drop_delta", 32'(int'(drop_cnt) - d0), 2);
`else
        chk("merge_drop_delta", 32'(int'(drop_cnt) - d0), 0);
`endif

        // timeout: no spi_done at all
        resp_en = 0;
        pulse(3'b100);
        wait_start(20);
        n = 0;
        while (busy === 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("timeout_cycles", 32'(n), 32'(TIMEOUT));
        chk("timeout_err_set", 32'(timeout_err), 1);
        resp_en = 1; resp_lo = 2; resp_hi = 2;
        pulse(3'b010); wait_quiet(100);
        chk("timeout_err_sticky", 32'(timeout_err), 1);

        // randomized traffic, including late and stray spi_done
        resp_lo = 1; resp_hi = 20; stray_en = 1;
        repeat (1500) begin
            btn_pulse = 3'b000;
            for (int i = 0; i < 3; i++) btn_pulse[i] = ($urandom_range(0, 5) == 0);
            spi_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        btn_pulse = 3'b000; spi_ready = 1'b1; stray_en = 0;
        wait_quiet(400);

        // reset during WAIT with two events pending
        resp_lo = 10; resp_hi = 10;
        pulse(3'b001);
        wait_start(20);
        @(negedge clk);
        pulse(3'b110);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_spi_start", 32'(spi_start), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_grant_id", 32'(grant_id), 2);
        chk("mid_rst_tx_data", 32'(spi_tx_data), 0);
        chk("mid_rst_run", 32'(run_state), 0);
        chk("mid_rst_terr", 32'(timeout_err), 0);
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        starts = 0;
        repeat (30) begin
            @(negedge clk);
            if (spi_start === 1'b1) starts++;
        end
        chk("no_start_after_rst", 32'(starts), 0);
        pulse(3'b100); wait_quiet(100);
        chk("post_rst_mode", 32'(mode_state), 1);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
